// File: rtl/noc_flit_reader_if.sv
// Output stream of the flit reader toward the switch allocator.
// Carries one flit and its framing/route sideband, with a valid/ready handshake.
interface noc_flit_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [4:0]            out_port;
    logic                  out_head;
    logic                  out_tail;

    modport master (
        output out_valid,
        output out_data,
        output out_port,
        output out_head,
        output out_tail,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_port,
        input  out_head,
        input  out_tail,
        output out_ready
    );
endinterface

// File: rtl/noc_flit_reader.sv
// Read-side consumer of a router input FIFO. Pops flits, hides the RAM's one-cycle
// read latency behind a two-entry buffer, checks packet framing and tags every
// stored flit with a one-hot XY output-port select {L,S,N,W,E}.
module noc_flit_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    noc_flit_reader_if.master     out_if,
    output logic                  err
);

    localparam logic [1:0] TYPE_HEAD = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b01;

    localparam logic [1:0] LOC_X = 2'(LOCAL_X);
    localparam logic       LOC_Y = 1'(LOCAL_Y);

    localparam logic [4:0] PORT_E = 5'b00001;
    localparam logic [4:0] PORT_W = 5'b00010;
    localparam logic [4:0] PORT_N = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_L = 5'b10000;

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    // Dimension-ordered routing: X is resolved completely before Y.
    function automatic logic [4:0] route_of(input logic [1:0] dst_x, input logic dst_y);
        logic [4:0] sel;
        if (dst_x > LOC_X)      sel = PORT_E;
        else if (dst_x < LOC_X) sel = PORT_W;
        else if (dst_y > LOC_Y) sel = PORT_S;
        else if (dst_y < LOC_Y) sel = PORT_N;
        else                    sel = PORT_L;
        return sel;
    endfunction

    state_t                state_q, state_d;
    logic [4:0]            route_q, route_d;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic [1:0]            occ_q, occ_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [4:0]            buf_port_q [2];
    logic [4:0]            buf_port_d [2];
    logic [1:0]            buf_head_q, buf_head_d;
    logic [1:0]            buf_tail_q, buf_tail_d;

    logic                  out_valid;
    logic                  pop;
    logic [2:0]            pending;
    logic [1:0]            flit_type;
    logic                  store;
    logic [4:0]            flit_route;
    logic                  wr_idx;

    assign out_valid        = (occ_q != 2'd0);
    assign out_if.out_valid = out_valid;
    assign out_if.out_data  = buf_data_q[rd_ptr_q];
    assign out_if.out_port  = buf_port_q[rd_ptr_q];
    assign out_if.out_head  = buf_head_q[rd_ptr_q];
    assign out_if.out_tail  = buf_tail_q[rd_ptr_q];
    assign err              = err_q;

    // Issue a pop only when the flit it returns is guaranteed a free buffer slot.
    always_comb begin
        pop        = out_valid && out_if.out_ready;
        pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !rst && !fifo_empty && (pending < 3'd2);
        inflight_d = fifo_rd_en && !fifo_empty;
    end

    // Framing check on the flit arriving from the RAM; decides store/drop and its route.
    always_comb begin
        flit_type  = fifo_rd_data[DATA_WIDTH-1 -: 2];
        store      = 1'b0;
        flit_route = route_q;
        state_d    = state_q;
        route_d    = route_q;
        err_d      = 1'b0;
        if (inflight_q) begin
            if (state_q == PKT && !flit_type[1]) begin
                store = 1'b1;
                if (flit_type == TYPE_TAIL) begin
                    state_d = IDLE;
                end
            end else begin
                if (state_q == PKT) begin
                    err_d = 1'b1;
                end
                if (flit_type[1]) begin
                    store      = 1'b1;
                    flit_route = route_of(fifo_rd_data[DATA_WIDTH-3 -: 2],
                                          fifo_rd_data[DATA_WIDTH-5]);
                    if (flit_type == TYPE_HEAD) begin
                        state_d = PKT;
                        route_d = flit_route;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Two-entry circular buffer: append behind the head entry, retire on handshake.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_port_d = buf_port_q;
        buf_head_d = buf_head_q;
        buf_tail_d = buf_tail_q;
        wr_idx     = rd_ptr_q ^ occ_q[0];
        if (store) begin
            buf_data_d[wr_idx] = fifo_rd_data;
            buf_port_d[wr_idx] = flit_route;
            buf_head_d[wr_idx] = flit_type[1];
            buf_tail_d[wr_idx] = flit_type[0];
        end
        occ_d    = occ_q + {1'b0, store} - {1'b0, pop};
        rd_ptr_d = rd_ptr_q ^ pop;
    end

    // State registers; reset drops any buffered or in-flight flit and closes the packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            route_q    <= 5'd0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            buf_head_q <= 2'b00;
            buf_tail_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_port_q[i] <= 5'd0;
            end
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_head_q <= buf_head_d;
            buf_tail_q <= buf_tail_d;
            buf_data_q <= buf_data_d;
            buf_port_q <= buf_port_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_reader.sv
// Directed bench for noc_flit_reader. Two instances at different mesh positions share
// one behavioural FIFO so the same flit stream exercises both routing viewpoints.
module tb_noc_flit_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  port;
        logic        head;
        logic        tail;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data = 32'd0;
    logic        fifo_rd_en_a, fifo_rd_en_b;
    logic        err_a, err_b;

    logic [31:0] fifo_mem [64];
    int          wr_idx = 0;
    int          rd_idx = 0;

    flit_t       got_a[$];
    flit_t       got_b[$];

    int          checks = 0;
    int          errors = 0;

    noc_flit_reader_if #(.DATA_WIDTH(32)) if_a ();
    noc_flit_reader_if #(.DATA_WIDTH(32)) if_b ();

    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign fifo_empty     = (wr_idx == rd_idx);

    noc_flit_reader #(.DATA_WIDTH(32), .LOCAL_X(1), .LOCAL_Y(0)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en_a),
        .out_if       (if_a),
        .err          (err_a)
    );

    noc_flit_reader #(.DATA_WIDTH(32), .LOCAL_X(2), .LOCAL_Y(1)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en_b),
        .out_if       (if_b),
        .err          (err_b)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // FIFO RAM model: read data appears one cycle after an accepted pop.
    always @(posedge clk) begin
        if (fifo_rd_en_a && !fifo_empty) begin
            fifo_rd_data <= fifo_mem[rd_idx % 64];
            rd_idx       <= rd_idx + 1;
        end
    end

    // Transfer monitor, sampling just before the edge that completes the handshake.
    always @(negedge clk) begin
        #4;
        if (if_a.out_valid && if_a.out_ready)
            got_a.push_back({if_a.out_data, if_a.out_port, if_a.out_head, if_a.out_tail});
        if (if_b.out_valid && if_b.out_ready)
            got_b.push_back({if_b.out_data, if_b.out_port, if_b.out_head, if_b.out_tail});
    end

    function automatic flit_t mk(input logic [31:0] d, input logic [4:0] p,
                                 input logic h, input logic t);
        return {d, p, h, t};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] flit);
        fifo_mem[wr_idx % 64] = flit;
        wr_idx = wr_idx + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // ---------------- reset and idle ----------------
        repeat (2) tick();
        rst = 1'b0;
        checkOutput("rst_outputs",
                    {if_a.out_data, if_a.out_port, if_a.out_head, if_a.out_tail}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("t1_idle%0d", i), {fifo_rd_en_a, if_a.out_valid, err_a}, 64'd0);
        end

        // ---------------- head/body/tail eastbound ----------------
        out_ready = 1'b1;
        got_a.delete();
        got_b.delete();
        tick();
        applyStimulus(32'hB800_0123);
        applyStimulus(32'h0000_0456);
        applyStimulus(32'h4000_0789);
        #1;
        checkOutput("t2_rd_en_first", fifo_rd_en_a, 1'b1);
        checkOutput("t2_valid_n0", if_a.out_valid, 1'b0);
        tick();
        checkOutput("t2_valid_n1", if_a.out_valid, 1'b0);
        tick();
        checkOutput("t2_valid_n2", if_a.out_valid, 1'b1);
        checkOutput("t2_out_n2",
                    {if_a.out_data, if_a.out_port, if_a.out_head, if_a.out_tail},
                    mk(32'hB800_0123, 5'b00001, 1'b1, 1'b0));
        repeat (5) tick();
        checkOutput("t2_count", got_a.size(), 3);
        checkOutput("t2_f0", got_a[0], mk(32'hB800_0123, 5'b00001, 1'b1, 1'b0));
        checkOutput("t2_f1", got_a[1], mk(32'h0000_0456, 5'b00001, 1'b0, 1'b0));
        checkOutput("t2_f2", got_a[2], mk(32'h4000_0789, 5'b00001, 1'b0, 1'b1));
        checkOutput("t2_b_f0", got_b[0], mk(32'hB800_0123, 5'b00001, 1'b1, 1'b0));

        // ---------------- single-flit packets ----------------
        got_a.delete();
        got_b.delete();
        tick();
        applyStimulus(32'hE800_0011);
        applyStimulus(32'hE000_0022);
        applyStimulus(32'hC800_0033);
        repeat (7) tick();
        checkOutput("t3_count_b", got_b.size(), 3);
        checkOutput("t3_b0", got_b[0], mk(32'hE800_0011, 5'b10000, 1'b1, 1'b1));
        checkOutput("t3_b1", got_b[1], mk(32'hE000_0022, 5'b00100, 1'b1, 1'b1));
        checkOutput("t3_b2", got_b[2], mk(32'hC800_0033, 5'b00010, 1'b1, 1'b1));
        checkOutput("t3_a0", got_a[0], mk(32'hE800_0011, 5'b00001, 1'b1, 1'b1));
        checkOutput("t3_a1", got_a[1], mk(32'hE000_0022, 5'b00001, 1'b1, 1'b1));
        checkOutput("t3_a2", got_a[2], mk(32'hC800_0033, 5'b00010, 1'b1, 1'b1));

        // ---------------- backpressure on an 8-flit packet ----------------
        got_a.delete();
        got_b.delete();
        out_ready = 1'b0;
        tick();
        applyStimulus(32'h9000_0000);
        for (int i = 1; i < 7; i++) applyStimulus(i);
        applyStimulus(32'h4000_0007);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i >= 3) begin
                checkOutput($sformatf("t4_hold_rd_en%0d", i), fifo_rd_en_a, 1'b0);
                checkOutput($sformatf("t4_hold_out%0d", i),
                            {if_a.out_valid, if_a.out_data}, {1'b1, 32'h9000_0000});
            end
        end
        checkOutput("t4_none_during_hold", got_a.size(), 0);
        out_ready = 1'b1;
        repeat (8) tick();
        checkOutput("t4_count_rate", got_a.size(), 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t4_f%0d", i), got_a[i],
                        mk((i == 0) ? 32'h9000_0000 : (i == 7) ? 32'h4000_0007 : 32'(i),
                           5'b10000, i == 0, i == 7));
        end
        checkOutput("t4_b_head_port", got_b[0].port, 5'b00010);
        repeat (3) tick();
        checkOutput("t4_count_final", got_a.size(), 8);
        checkOutput("t4_drained", if_a.out_valid, 1'b0);

        // ---------------- orphan body flit in IDLE ----------------
        got_a.delete();
        got_b.delete();
        tick();
        applyStimulus(32'h0000_0AAA);
        tick();
        checkOutput("t5_err_n1", {err_a, if_a.out_valid}, 2'b00);
        tick();
        checkOutput("t5_err_n2", {err_a, err_b, if_a.out_valid}, 3'b110);
        tick();
        checkOutput("t5_err_n3", {err_a, if_a.out_valid}, 2'b00);
        applyStimulus(32'h9800_0001);
        applyStimulus(32'h4000_0002);
        repeat (6) tick();
        checkOutput("t5_count", got_a.size(), 2);
        checkOutput("t5_a0", got_a[0], mk(32'h9800_0001, 5'b01000, 1'b1, 1'b0));
        checkOutput("t5_a1", got_a[1], mk(32'h4000_0002, 5'b01000, 1'b0, 1'b1));
        checkOutput("t5_b0", got_b[0], mk(32'h9800_0001, 5'b00010, 1'b1, 1'b0));

        // ---------------- reset in the middle of a packet ----------------
        got_a.delete();
        got_b.delete();
        out_ready = 1'b0;
        tick();
        applyStimulus(32'h9800_0050);
        applyStimulus(32'h0000_0051);
        repeat (4) tick();
        checkOutput("t6_full", {if_a.out_valid, if_a.out_data}, {1'b1, 32'h9800_0050});
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_outputs",
                    {if_a.out_valid, if_a.out_data, if_a.out_port, if_a.out_head,
                     if_a.out_tail, fifo_rd_en_a, err_a}, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        out_ready = 1'b1;
        got_a.delete();
        got_b.delete();
        tick();
        checkOutput("t6_no_stale", if_a.out_valid, 1'b0);
        applyStimulus(32'h9800_0060);
        applyStimulus(32'h4000_0061);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("t6_no_err%0d", i), err_a, 1'b0);
        end
        checkOutput("t6_count", got_a.size(), 2);
        checkOutput("t6_a0", got_a[0], mk(32'h9800_0060, 5'b01000, 1'b1, 1'b0));
        checkOutput("t6_a1", got_a[1], mk(32'h4000_0061, 5'b01000, 1'b0, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
